// File: rtl/uart_tx_subsystem_if.sv
// Producer-side handshake and serial line of the UART transmit path.
// The producer drives start/data_in; the transmitter returns tx, tx_busy and the baud strobe.
interface uart_tx_subsystem_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  tx;
  logic                  tx_busy;
  logic                  baud_tick;

  modport master (
    output start, data_in,
    input  tx, tx_busy, baud_tick
  );

  modport slave (
    input  start, data_in,
    output tx, tx_busy, baud_tick
  );
endinterface

// File: rtl/uart_tx_subsystem.sv
// UART transmit path: a free-running oversampled baud strobe generator feeding a
// start/data/[parity]/stop frame serializer with a start/busy producer handshake.
module Baud_Tick #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic baud_tick
);
  localparam int DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign baud_tick = tick_q;
endmodule

module UART_TX #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx,
  output logic                  tx_busy
);
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  // Rate parameters only document the intended line speed; timing comes from baud_tick.
  if (BAUD_RATE <= 0 || CLOCK_FREQ <= 0) begin : g_rate_info_unused
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  bit_done;

  assign bit_done = baud_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    par_d   = par_q;

    // Ticks are only counted inside a frame, so one landing on the accept edge is dropped.
    if (state_q != S_IDLE && baud_tick) begin
      tick_d = bit_done ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          shreg_d = data_in;
          tick_d  = '0;
          bit_d   = '0;
          par_d   = (PARITY == 2) ? ~(^data_in) : ^data_in;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from next state so tx is a clean register output.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != S_IDLE);
endmodule

module uart_tx_subsystem #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_subsystem_if.slave  tx_if
);
  logic baud_tick;

  Baud_Tick #(
    .BAUD_RATE  (BAUD_RATE),
    .CLOCK_FREQ (CLOCK_FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick)
  );

  UART_TX #(
    .DATA_WIDTH (DATA_WIDTH),
    .BAUD_RATE  (BAUD_RATE),
    .CLOCK_FREQ (CLOCK_FREQ),
    .OVERSAMPLE (OVERSAMPLE),
    .PARITY     (PARITY)
  ) u_uart_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_tick (baud_tick),
    .start     (tx_if.start),
    .data_in   (tx_if.data_in),
    .tx        (tx_if.tx),
    .tx_busy   (tx_if.tx_busy)
  );

  assign tx_if.baud_tick = baud_tick;
endmodule

// File: tb/tb_uart_tx_subsystem.sv
// Scoreboarded bench for uart_tx_subsystem: stimulus queues expected bytes, a line
// monitor decodes tx frames and checks them. Scaled rates give DIV=5, 80 clocks per bit.
module tb_uart_tx_subsystem;
  localparam int DIV = 5;
  localparam int OS  = 16;
  localparam int BIT = DIV * OS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_subsystem_if #(.DATA_WIDTH(8)) if_n ();
  uart_tx_subsystem_if #(.DATA_WIDTH(8)) if_e ();
  uart_tx_subsystem_if #(.DATA_WIDTH(8)) if_o ();

  uart_tx_subsystem #(.DATA_WIDTH(8), .BAUD_RATE(1), .CLOCK_FREQ(80), .OVERSAMPLE(OS), .PARITY(0))
    dut_n (.clk(clk), .rst_n(rst_n), .tx_if(if_n));
  uart_tx_subsystem #(.DATA_WIDTH(8), .BAUD_RATE(1), .CLOCK_FREQ(80), .OVERSAMPLE(OS), .PARITY(1))
    dut_e (.clk(clk), .rst_n(rst_n), .tx_if(if_e));
  uart_tx_subsystem #(.DATA_WIDTH(8), .BAUD_RATE(1), .CLOCK_FREQ(80), .OVERSAMPLE(OS), .PARITY(2))
    dut_o (.clk(clk), .rst_n(rst_n), .tx_if(if_o));

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   frames = 0;
  int   sel    = 0;
  logic mon_en = 1'b0;
  logic mon_tx, mon_busy;

  always_comb begin
    mon_tx   = if_n.tx;
    mon_busy = if_n.tx_busy;
    if (sel == 1) begin
      mon_tx   = if_e.tx;
      mon_busy = if_e.tx_busy;
    end else if (sel == 2) begin
      mon_tx   = if_o.tx;
      mon_busy = if_o.tx_busy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic s, input logic [7:0] d);
    case (sel)
      1:       begin if_e.start = s; if_e.data_in = d; end
      2:       begin if_o.start = s; if_o.data_in = d; end
      default: begin if_n.start = s; if_n.data_in = d; end
    endcase
  endtask

  task automatic wait_busy(input logic v, input int limit, input string name, output int n);
    n = 0;
    while (mon_busy !== v && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (mon_busy !== v) begin
      errors++;
      $display("FAIL %s: tx_busy stayed %b after %0d cycles, needed %b", name, mon_busy, n, v);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic p, input int hold);
    int n;
    sb.push_back(exp_t'{d: d, p: p});
    @(posedge clk); #1;
    set_in(1'b1, d);
    wait_busy(1'b1, 4, "accept", n);
    check("start_latency", n, 1);
    repeat (hold) @(posedge clk);
    #1;
    set_in(1'b0, d);
    wait_busy(1'b0, 12 * BIT, "frame_end", n);
    check("idle_tx", mon_tx, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Line monitor: samples each bit near its centre and scores the decoded frame.
  initial begin : monitor
    logic       fr [0:11];
    int         nb, blen, lo, hi;
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && mon_tx === 1'b0) begin
        nb   = (sel == 0) ? 10 : 11;
        blen = mon_busy ? 1 : 0;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c < ((b == 0) ? BIT / 2 - 1 : BIT); c++) begin
            @(negedge clk);
            if (mon_busy) blen++;
          end
          fr[b] = mon_tx;
        end
        for (int g = 0; g < 2 * BIT && mon_busy; g++) begin
          @(negedge clk);
          if (mon_busy) blen++;
        end
        frames++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: frame seen with empty scoreboard");
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < 8; i++) got[i] = fr[i + 1];
          check("start_bit", fr[0], 0);
          check("data", got, e.d);
          if (nb == 11) check("parity", fr[9], e.p);
          check("stop_bit", fr[nb - 1], 1);
          lo = nb * BIT - (DIV - 1);
          hi = nb * BIT;
          checks++;
          if (blen < lo || blen > hi) begin
            errors++;
            $display("FAIL busy_len: got %0d required %0d..%0d", blen, lo, hi);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(40000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] sweep [0:7];
    int n;
    sweep = '{8'h55, 8'hAA, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h3C, 8'hC3};
    if_n.start = 1'b0; if_n.data_in = '0;
    if_e.start = 1'b0; if_e.data_in = '0;
    if_o.start = 1'b0; if_o.data_in = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", if_n.tx, 1);
    check("rst_busy", if_n.tx_busy, 0);
    check("rst_tick", if_n.baud_tick, 0);
    check("rst_tx_even", if_e.tx, 1);
    check("rst_tx_odd", if_o.tx, 1);
    rst_n = 1'b1;

    n = 0;
    while (!if_n.baud_tick && n < 4 * DIV) begin
      @(posedge clk); #1;
      n++;
    end
    check("tick_seen", if_n.baud_tick, 1);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!if_n.baud_tick && n < 4 * DIV);
      check("tick_period", n, DIV);
    end

    mon_en = 1'b1;
    send(8'h55, 1'b0, BIT);
    repeat (2 * BIT) @(posedge clk);
    #1;
    check("no_second_frame", mon_busy, 0);
    check("frames_after_single", frames, 1);

    foreach (sweep[i]) send(sweep[i], 1'b0, 0);

    // Disturb data_in and start while the first frame is in its data bits.
    sb.push_back(exp_t'{d: 8'hA5, p: 1'b0});
    set_in(1'b1, 8'hA5);
    wait_busy(1'b1, 4, "dist_accept", n);
    set_in(1'b0, 8'hA5);
    repeat (3 * BIT) @(posedge clk);
    #1;
    set_in(1'b1, 8'h5A);
    @(posedge clk); #1;
    set_in(1'b0, 8'h00);
    wait_busy(1'b0, 12 * BIT, "dist_end", n);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back: start held through the first IDLE cycle launches the next frame.
    sb.push_back(exp_t'{d: 8'h3C, p: 1'b0});
    sb.push_back(exp_t'{d: 8'hC3, p: 1'b0});
    set_in(1'b1, 8'h3C);
    wait_busy(1'b1, 4, "b2b_accept", n);
    repeat (BIT) @(posedge clk);
    #1;
    set_in(1'b1, 8'hC3);
    wait_busy(1'b0, 12 * BIT, "b2b_first_end", n);
    wait_busy(1'b1, 4, "b2b_restart", n);
    check("b2b_restart_latency", n, 1);
    set_in(1'b0, 8'h00);
    wait_busy(1'b0, 12 * BIT, "b2b_second_end", n);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the data bits aborts the frame immediately.
    mon_en = 1'b0;
    set_in(1'b1, 8'hF0);
    wait_busy(1'b1, 4, "rstmid_accept", n);
    set_in(1'b0, 8'hF0);
    repeat (3 * BIT) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", mon_tx, 1);
    check("rstmid_busy", mon_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    send(8'h96, 1'b0, 0);

    sel = 1;
    send(8'h7F, 1'b1, 0);
    send(8'h03, 1'b0, 0);
    sel = 2;
    send(8'h7F, 1'b0, 0);
    send(8'h03, 1'b1, 0);

    repeat (2 * BIT) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    check("frame_count", frames, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
